// File: rtl/gpio_bus_master.sv
// gpio_bus_master: register-bus initiator for the GPIO block.
// Takes WRITE / READ / SET / CLR / TGL commands over a valid/ready port.
// Each command becomes one or two single-cycle sel/we bus accesses.
// Every command produces exactly one response over a valid/ready port.
// All outputs come from registers, so cmd_* has no combinational path to o_*.

module gpio_bus_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  o_sel,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata
);

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_CLR   = 3'd3;
    localparam logic [2:0] OP_TGL   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_r;
    logic [2:0]              op_r;
    logic [DATA_WIDTH-1:0]   mask_r;
    logic [DATA_WIDTH-1:0]   old_r;

    // Opcodes 5..7 are rejected without touching the bus.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_TGL);
    endfunction

    // Computes the value written back by a read-modify-write.
    function automatic logic [DATA_WIDTH-1:0] rmw_apply(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        case (op)
            OP_SET:  res = old | mask;
            OP_CLR:  res = old & ~mask;
            OP_TGL:  res = old ^ mask;
            default: res = old;
        endcase
        return res;
    endfunction

    // Command/response sequencer with registered bus and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            op_r      <= 3'd0;
            mask_r    <= {DATA_WIDTH{1'b0}};
            old_r     <= {DATA_WIDTH{1'b0}};
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
            rsp_err   <= 1'b0;
            o_sel     <= 1'b0;
            o_we      <= 1'b0;
            o_addr    <= {ADDR_WIDTH{1'b0}};
            o_wdata   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_r      <= cmd_op;
                        mask_r    <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        if (!op_legal(cmd_op)) begin
                            // Illegal op: answer at once, the bus stays idle.
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= {DATA_WIDTH{1'b0}};
                        end else if (cmd_op == OP_WRITE) begin
                            state_r <= ST_WR;
                            o_sel   <= 1'b1;
                            o_we    <= 1'b1;
                            o_addr  <= cmd_addr;
                            o_wdata <= cmd_wdata;
                        end else begin
                            // READ and all RMW ops start with a read cycle.
                            state_r <= ST_RD;
                            o_sel   <= 1'b1;
                            o_we    <= 1'b0;
                            o_addr  <= cmd_addr;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                ST_RD: begin
                    old_r <= i_rdata;
                    if (op_r == OP_READ) begin
                        state_r   <= ST_RESP;
                        o_sel     <= 1'b0;
                        o_we      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= i_rdata;
                    end else begin
                        // Write-back follows in the very next cycle, keeping RMW atomic.
                        state_r <= ST_WR;
                        o_sel   <= 1'b1;
                        o_we    <= 1'b1;
                        o_wdata <= rmw_apply(op_r, i_rdata, mask_r);
                    end
                end

                ST_WR: begin
                    state_r   <= ST_RESP;
                    o_sel     <= 1'b0;
                    o_we      <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    if (op_r == OP_WRITE) begin
                        rsp_rdata <= {DATA_WIDTH{1'b0}};
                    end else begin
                        rsp_rdata <= old_r;
                    end
                end

                ST_RESP: begin
                    o_sel <= 1'b0;
                    o_we  <= 1'b0;
                    if (rsp_ready) begin
                        state_r   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= {DATA_WIDTH{1'b0}};
                        cmd_ready <= 1'b1;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= {DATA_WIDTH{1'b0}};
                    o_sel     <= 1'b0;
                    o_we      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Directed bench for gpio_bus_master with a 4-bit GPIO slave (DATA@0x0, DIR@0x4, READ@0x8).
module tb_gpio_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        o_sel;
    logic        o_we;
    logic [3:0]  o_addr;
    logic [31:0] o_wdata;
    logic [31:0] i_rdata;

    logic [3:0]  gpio_data = 4'h0;
    logic [3:0]  gpio_dir  = 4'h0;
    int          sel_total = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    gpio_bus_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .o_sel(o_sel), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata), .i_rdata(i_rdata)
    );

    always #5 clk = ~clk;

    // GPIO slave register writes.
    always @(posedge clk) begin
        if (o_sel && o_we) begin
            case (o_addr)
                4'h0:    gpio_data <= o_wdata[3:0];
                4'h4:    gpio_dir  <= o_wdata[3:0];
                default: ;
            endcase
        end
    end

    // GPIO slave combinational read mux (READ@0x8 loops back the pins = DATA).
    always_comb begin
        i_rdata = 32'h0;
        case (o_addr)
            4'h0:    i_rdata = {28'h0, gpio_data};
            4'h4:    i_rdata = {28'h0, gpio_dir};
            4'h8:    i_rdata = {28'h0, gpio_data};
            default: i_rdata = 32'h0;
        endcase
    end

    // Counts bus-select cycles.
    always @(posedge clk) begin
        if (o_sel) sel_total <= sel_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command with rsp_ready=1 and check latency, response and select count.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] addr,
                           input logic [31:0] wdata, input int exp_lat,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_sels);
        int lat;
        int sel0;
        sel0      = sel_total;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        chk({tag, "_ready"}, {31'h0, cmd_ready}, 32'h1);
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        chk({tag, "_sels"}, sel_total - sel0, exp_sels);
        tick();
        chk({tag, "_rv_off"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_idle"}, {31'h0, cmd_ready}, 32'h1);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_addr  = 4'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_sel",       {31'h0, o_sel}, 32'h0);
        chk("rst_we",        {31'h0, o_we},  32'h0);
        chk("rst_addr",      {28'h0, o_addr}, 32'h0);
        chk("rst_wdata",     o_wdata, 32'h0);
        reset = 1'b0;
        tick();

        // 1: WRITE DIR=0xF
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 4'h4; cmd_wdata = 32'hF;
        tick();
        cmd_valid = 1'b0;
        chk("t1_sel",   {31'h0, o_sel}, 32'h1);
        chk("t1_we",    {31'h0, o_we},  32'h1);
        chk("t1_addr",  {28'h0, o_addr}, 32'h4);
        chk("t1_wdata", o_wdata, 32'hF);
        chk("t1_rv_early", {31'h0, rsp_valid}, 32'h0);
        chk("t1_busy",  {31'h0, cmd_ready}, 32'h0);
        tick();
        chk("t1_rv",    {31'h0, rsp_valid}, 32'h1);
        chk("t1_rdata", rsp_rdata, 32'h0);
        chk("t1_err",   {31'h0, rsp_err}, 32'h0);
        chk("t1_sel_off", {31'h0, o_sel}, 32'h0);
        chk("t1_dir",   {28'h0, gpio_dir}, 32'hF);
        tick();
        chk("t1_rv_off", {31'h0, rsp_valid}, 32'h0);
        chk("t1_idle",  {31'h0, cmd_ready}, 32'h1);

        // 2: WRITE DATA=5, then READ
        run_cmd("t2w", 3'd0, 4'h0, 32'h5, 2, 32'h0, 1'b0, 1);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 4'h0; cmd_wdata = 32'h0;
        tick();
        cmd_valid = 1'b0;
        chk("t2_rd_sel", {31'h0, o_sel}, 32'h1);
        chk("t2_rd_we",  {31'h0, o_we},  32'h0);
        chk("t2_rd_addr", {28'h0, o_addr}, 32'h0);
        tick();
        chk("t2_rv",    {31'h0, rsp_valid}, 32'h1);
        chk("t2_rdata", rsp_rdata, 32'h5);
        tick();

        // 3: SET mask 0xA on DATA=5, then TGL mask 0x3
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_addr = 4'h0; cmd_wdata = 32'hA;
        tick();
        cmd_valid = 1'b0;
        chk("t3_rd_sel", {31'h0, o_sel}, 32'h1);
        chk("t3_rd_we",  {31'h0, o_we},  32'h0);
        tick();
        chk("t3_wr_sel", {31'h0, o_sel}, 32'h1);
        chk("t3_wr_we",  {31'h0, o_we},  32'h1);
        chk("t3_wr_wdata", o_wdata, 32'hF);
        chk("t3_rv_early", {31'h0, rsp_valid}, 32'h0);
        tick();
        chk("t3_rv",    {31'h0, rsp_valid}, 32'h1);
        chk("t3_rdata", rsp_rdata, 32'h5);
        chk("t3_data",  {28'h0, gpio_data}, 32'hF);
        tick();
        run_cmd("t3tgl", 3'd4, 4'h0, 32'h3, 3, 32'hF, 1'b0, 2);
        chk("t3_tgl_data", {28'h0, gpio_data}, 32'hC);

        // 4: READ under back-pressure, competing command held off
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 4'h0; cmd_wdata = 32'h0;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t4_rv", {31'h0, rsp_valid}, 32'h1);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 4'h0; cmd_wdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_rv",    {31'h0, rsp_valid}, 32'h1);
            chk("t4_hold_rdata", rsp_rdata, 32'hC);
            chk("t4_hold_ready", {31'h0, cmd_ready}, 32'h0);
            chk("t4_hold_sel",   {31'h0, o_sel}, 32'h0);
            tick();
        end
        chk("t4_data_kept", {28'h0, gpio_data}, 32'hC);
        rsp_ready = 1'b1;
        tick();
        chk("t4_rv_off", {31'h0, rsp_valid}, 32'h0);
        chk("t4_idle",   {31'h0, cmd_ready}, 32'h1);
        chk("t4_idle_sel", {31'h0, o_sel}, 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("t4_w_we",    {31'h0, o_we}, 32'h1);
        chk("t4_w_wdata", o_wdata, 32'h0);
        tick();
        chk("t4_w_rv", {31'h0, rsp_valid}, 32'h1);
        tick();
        chk("t4_w_data", {28'h0, gpio_data}, 32'h0);

        // 5: illegal op, then a normal READ
        run_cmd("t5ill", 3'd6, 4'h0, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 0);
        run_cmd("t5rd",  3'd1, 4'h0, 32'h0, 2, 32'h0, 1'b0, 1);

        // 6: reset during the WR cycle of a CLR
        run_cmd("t6w", 3'd0, 4'h0, 32'hF, 2, 32'h0, 1'b0, 1);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_addr = 4'h0; cmd_wdata = 32'h3;
        tick();
        cmd_valid = 1'b0;
        chk("t6_rd_sel", {31'h0, o_sel}, 32'h1);
        tick();
        chk("t6_wr_we",    {31'h0, o_we}, 32'h1);
        chk("t6_wr_wdata", o_wdata, 32'hC);
        reset = 1'b1;
        #1;
        chk("t6_rst_sel",   {31'h0, o_sel}, 32'h0);
        chk("t6_rst_we",    {31'h0, o_we},  32'h0);
        chk("t6_rst_rv",    {31'h0, rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("t6_ready", {31'h0, cmd_ready}, 32'h1);
        chk("t6_no_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("t6_data",  {28'h0, gpio_data}, 32'hF);
        run_cmd("t6rd", 3'd1, 4'h0, 32'h0, 2, 32'hF, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
